pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the OpenMIPS 6-stage stall vector (pc, if, id, ex, mem, wb).
- Generalises the EX/MEM register: the payload width and stage position are parameters.
- Adds a valid bit, an explicit flush input and a saturating hold-cycle counter.
- Adds a side channel for multi-cycle state (e.g. hilo temp plus cycle count for madd/msub) that survives bubbles and holds.

Parameters:
- DATA_W, 64, payload width (wd/wreg/wdata/aluop/... concatenated by the instantiating stage)
- SIDE_W, 66, multi-cycle side-state width (default: 64-bit hilo plus 2-bit cnt)
- STALL_W, 6, stall vector width
- STAGE, 3, index of the upstream stage in stall; downstream is STAGE+1; legal range 0..STALL_W-2
- BUBBLE, {DATA_W{1'b0}}, payload value driven for a bubble/NOP

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high (`RstEnable`)
- stall  in  STALL_W  stall vector from ctrl; `Stop`=1
- flush  in  1  exception flush; kills the stage contents
- up_valid  in  1  upstream stage holds a real instruction
- up_data  in  DATA_W  upstream payload
- side_i  in  SIDE_W  side state from upstream (multi-cycle op in progress)
- dn_valid  out  1  register holds a real instruction
- dn_data  out  DATA_W  registered payload to downstream
- side_o  out  SIDE_W  registered side state, fed back to upstream
- hold_cnt  out  8  consecutive cycles the register has held, saturating at 255

Behaviour:
- Define up_stop = stall[STAGE] and dn_stop = stall[STAGE+1].
- Each rising edge, exactly one case applies, first match wins:
  1. rst=1: dn_valid=0, dn_data=BUBBLE, side_o=0, hold_cnt=0.
  2. flush=1: dn_valid=0, dn_data=BUBBLE, side_o=0, hold_cnt=0. Flush overrides any stall.
  3. up_stop=1, dn_stop=0 (bubble): dn_valid=0, dn_data=BUBBLE, side_o<=side_i, hold_cnt=0.
  4. up_stop=0 (advance): dn_valid<=up_valid, dn_data<=up_data, side_o=0, hold_cnt=0.
     - If up_valid=0, dn_data=BUBBLE regardless of up_data.
  5. Otherwise, up_stop=1 and dn_stop=1 (hold): dn_valid and dn_data unchanged; side_o<=side_i; hold_cnt<=hold_cnt+1, saturating at 255.
- The pattern up_stop=0 with dn_stop=1 is illegal from ctrl. It resolves as advance (case 4), and a simulation-only assertion fires.
- Latency is 1 cycle up_data to dn_data when advancing. No combinational path from any input to any output.
- Side state captured in bubble/hold is visible on side_o the next cycle. It clears on the cycle the instruction advances, so a multi-cycle op restarts from zero only after completion.
- Reset mid-hold or mid-bubble discards the side state.
- Elaboration error if STAGE > STALL_W-2.

Optional Feature:
- Macro PIPE_STAGE_STATS_EN adds outputs bubble_cnt[31:0] and hold_total[31:0].
  - bubble_cnt increments once per case-3 edge.
  - hold_total increments once per case-5 edge.
  - Both wrap modulo 2^32 and clear on rst only; flush does not clear them.
- Without the macro, neither port nor its counter logic exists, and the rest of the behaviour is identical.

Test Plan:
1. Reset release: rst=1 for 2 cycles, then rst=0 with stall=0, up_valid=1, up_data=0x1234 → during reset dn_valid=0, dn_data=0, side_o=0, hold_cnt=0; one edge after release dn_data=0x1234, dn_valid=1.
2. Bubble: stall=6'b001000 (STAGE=3), side_i=0x2_DEADBEEF_00000001 → dn_valid=0, dn_data=BUBBLE, side_o=0x2_DEADBEEF_00000001; next cycle stall=0 → side_o=0.
3. Hold and saturation:
   - load 0xAAAA, then stall=6'b011000 for 300 cycles → dn_data stays 0xAAAA, hold_cnt reaches 255 and stays there.
   - release → hold_cnt=0.
4. Flush priority: flush=1 with stall=6'b011000 while holding 0x5555 → dn_valid=0, dn_data=0, side_o=0.
5. Invalid upstream: stall=0, up_valid=0, up_data=0xFFFF → dn_data=BUBBLE, dn_valid=0.
6. With PIPE_STAGE_STATS_EN: 3 bubble cycles, then 4 hold cycles, then a flush → bubble_cnt=3, hold_total=4, both unchanged by the flush.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register driven by a ctrl stall vector: bubble, advance, hold, flush.
// Define PIPE_STAGE_STATS_EN to add the bubble_cnt / hold_total statistics outputs.
module pipe_stage_reg #(
   parameter int                DATA_W  = 64,
   parameter int                SIDE_W  = 66,
   parameter int                STALL_W = 6,
   parameter int                STAGE   = 3,
   parameter logic [DATA_W-1:0] BUBBLE  = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               up_valid,
   input  logic [DATA_W-1:0]  up_data,
   input  logic [SIDE_W-1:0]  side_i,
   output logic               dn_valid,
   output logic [DATA_W-1:0]  dn_data,
   output logic [SIDE_W-1:0]  side_o,
`ifdef PIPE_STAGE_STATS_EN
   output logic [31:0]        bubble_cnt,
   output logic [31:0]        hold_total,
`endif
   output logic [7:0]         hold_cnt
);

   if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE must lie in 0..STALL_W-2");
   end

   logic up_stop;
   logic dn_stop;
   logic stall_unused;
   logic do_clear;
   logic do_bubble;
   logic do_advance;
   logic do_hold;

   assign up_stop      = stall[STAGE];
   assign dn_stop      = stall[STAGE+1];
   assign stall_unused = ^stall;

   // Exactly one of the four actions is taken per edge; the illegal
   // up_stop=0/dn_stop=1 pattern falls into advance.
   always_comb begin
      do_clear   = rst | flush;
      do_bubble  = !do_clear && up_stop && !dn_stop;
      do_advance = !do_clear && !up_stop;
      do_hold    = !do_clear && up_stop && dn_stop;
   end

   always_ff @(posedge clk) begin
      if (do_clear) begin
         dn_valid <= 1'b0;
         dn_data  <= BUBBLE;
         side_o   <= '0;
         hold_cnt <= 8'd0;
      end else if (do_bubble) begin
         dn_valid <= 1'b0;
         dn_data  <= BUBBLE;
         side_o   <= side_i;
         hold_cnt <= 8'd0;
      end else if (do_advance) begin
         dn_valid <= up_valid;
         dn_data  <= up_valid ? up_data : BUBBLE;
         side_o   <= '0;
         hold_cnt <= 8'd0;
      end else if (do_hold) begin
         side_o <= side_i;
         if (hold_cnt != 8'hFF) hold_cnt <= hold_cnt + 8'd1;
      end
   end

`ifdef PIPE_STAGE_STATS_EN
   // Statistics survive flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt <= 32'd0;
         hold_total <= 32'd0;
      end else if (do_bubble) begin
         bubble_cnt <= bubble_cnt + 32'd1;
      end else if (do_hold) begin
         hold_total <= hold_total + 32'd1;
      end
   end
`endif

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst && !flush) begin
         assert (!(!up_stop && dn_stop))
            else $error("pipe_stage_reg: illegal stall pattern (upstream runs, downstream stopped)");
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised self-checking bench for pipe_stage_reg against a rule-level reference model.
module tb_pipe_stage_reg;

   localparam int DATA_W  = 64;
   localparam int SIDE_W  = 66;
   localparam int STALL_W = 6;
   localparam int STAGE   = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic [STALL_W-1:0] stall;
   logic               flush;
   logic               up_valid;
   logic [DATA_W-1:0]  up_data;
   logic [SIDE_W-1:0]  side_i;
   logic               dn_valid;
   logic [DATA_W-1:0]  dn_data;
   logic [SIDE_W-1:0]  side_o;
   logic [7:0]         hold_cnt;
`ifdef PIPE_STAGE_STATS_EN
   logic [31:0]        bubble_cnt;
   logic [31:0]        hold_total;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic [SIDE_W-1:0] m_side;
   int                m_hold;
   logic [31:0]       m_bub;
   logic [31:0]       m_htot;

   pipe_stage_reg #(
      .DATA_W (DATA_W),
      .SIDE_W (SIDE_W),
      .STALL_W(STALL_W),
      .STAGE  (STAGE)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .stall   (stall),
      .flush   (flush),
      .up_valid(up_valid),
      .up_data (up_data),
      .side_i  (side_i),
      .dn_valid(dn_valid),
      .dn_data (dn_data),
      .side_o  (side_o),
`ifdef PIPE_STAGE_STATS_EN
      .bubble_cnt(bubble_cnt),
      .hold_total(hold_total),
`endif
      .hold_cnt(hold_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge as the specification describes it, using the inputs held before the edge.
   task automatic model_edge();
      logic us, ds;
      us = stall[STAGE];
      ds = stall[STAGE+1];
      if (rst || flush) begin
         m_valid = 1'b0; m_data = '0; m_side = '0; m_hold = 0;
         if (rst) begin m_bub = 0; m_htot = 0; end
      end else if (us && !ds) begin
         m_valid = 1'b0; m_data = '0; m_side = side_i; m_hold = 0;
         m_bub = m_bub + 1;
      end else if (!us) begin
         m_valid = up_valid;
         m_data  = up_valid ? up_data : '0;
         m_side  = '0;
         m_hold  = 0;
      end else begin
         m_side = side_i;
         m_hold = (m_hold + 1 > 255) ? 255 : m_hold + 1;
         m_htot = m_htot + 1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("dn_valid", 128'(dn_valid), 128'(m_valid));
      check("dn_data",  128'(dn_data),  128'(m_data));
      check("side_o",   128'(side_o),   128'(m_side));
      check("hold_cnt", 128'(hold_cnt), 128'(m_hold));
`ifdef PIPE_STAGE_STATS_EN
      check("bubble_cnt", 128'(bubble_cnt), 128'(m_bub));
      check("hold_total", 128'(hold_total), 128'(m_htot));
`endif
   endtask

   initial begin
      int kind;
      m_valid = 1'b0; m_data = '0; m_side = '0; m_hold = 0; m_bub = 0; m_htot = 0;
      rst = 1'b1; stall = '0; flush = 1'b0; up_valid = 1'b1; up_data = 64'h1234; side_i = '0;

      // reset and release
      step(); step();
      check("rst_valid", 128'(dn_valid), 128'(0));
      check("rst_hold",  128'(hold_cnt), 128'(0));
      rst = 1'b0;
      step();
      check("rel_data",  128'(dn_data),  128'(64'h1234));
      check("rel_valid", 128'(dn_valid), 128'(1));

      // bubble carries side state, advance clears it
      stall  = 6'b001000;
      side_i = 66'h2_DEAD_BEEF_0000_0001;
      step();
      check("bub_side",  128'(side_o),   128'(66'h2_DEAD_BEEF_0000_0001));
      check("bub_valid", 128'(dn_valid), 128'(0));
      check("bub_data",  128'(dn_data),  128'(0));
      stall = '0;
      step();
      check("adv_side",  128'(side_o),   128'(0));

      // long hold saturates the counter
      up_valid = 1'b1; up_data = 64'hAAAA;
      step();
      stall = 6'b011000; up_data = 64'h7777;
      for (int i = 0; i < 300; i++) step();
      check("hold_data", 128'(dn_data),  128'(64'hAAAA));
      check("hold_sat",  128'(hold_cnt), 128'(255));
      stall = '0;
      step();
      check("hold_rel",  128'(hold_cnt), 128'(0));
      check("hold_adv",  128'(dn_data),  128'(64'h7777));

      // flush beats a hold
      up_data = 64'h5555;
      step();
      stall = 6'b011000;
      step(); step();
      flush = 1'b1;
      step();
      check("fl_valid", 128'(dn_valid), 128'(0));
      check("fl_data",  128'(dn_data),  128'(0));
      check("fl_side",  128'(side_o),   128'(0));
      flush = 1'b0; stall = '0;

      // invalid upstream gives a bubble payload
      up_valid = 1'b0; up_data = 64'hFFFF;
      step();
      check("inv_data",  128'(dn_data),  128'(0));
      check("inv_valid", 128'(dn_valid), 128'(0));

`ifdef PIPE_STAGE_STATS_EN
      rst = 1'b1; step(); rst = 1'b0;
      stall = 6'b001000;
      for (int i = 0; i < 3; i++) step();
      stall = 6'b011000;
      for (int i = 0; i < 4; i++) step();
      stall = '0; flush = 1'b1;
      step();
      flush = 1'b0;
      check("st_bubble", 128'(bubble_cnt), 128'(3));
      check("st_hold",   128'(hold_total), 128'(4));
`endif

      // randomised legal traffic
      for (int i = 0; i < 3000; i++) begin
         kind     = int'($urandom_range(0, 9));
         stall    = 6'($urandom);
         up_valid = 1'($urandom);
         up_data  = {$urandom, $urandom};
         side_i   = {2'($urandom), $urandom, $urandom};
         flush    = (kind == 9);
         rst      = ($urandom_range(0, 99) == 0);
         if (kind <= 3) begin
            stall[STAGE] = 1'b0; stall[STAGE+1] = 1'b0;
         end else if (kind <= 5) begin
            stall[STAGE] = 1'b1; stall[STAGE+1] = 1'b0;
         end else begin
            stall[STAGE] = 1'b1; stall[STAGE+1] = 1'b1;
         end
         step();
      end
      rst = 1'b0; flush = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
